// File: rtl/calc_if.sv
// calc_if: keypad/DIP inputs and display-facing outputs of calc_engine.
interface calc_if #(
  parameter int DIGITS = 4,
  parameter int W = 14,
  parameter int RW = 28
);
  logic key_tick;
  logic [11:0] sw;
  logic [7:0] dipsw;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [RW-1:0] result;
  logic neg;
  logic [2:0] op_code;
  logic [$clog2(DIGITS+1)-1:0] digit_cnt;
  logic [2:0] state;
  logic busy;
  logic result_valid;
  logic err;
  modport master (
    output key_tick, sw, dipsw,
    input operand_a, operand_b, result, neg, op_code, digit_cnt, state, busy, result_valid, err
  );
  modport slave (
    input key_tick, sw, dipsw,
    output operand_a, operand_b, result, neg, op_code, digit_cnt, state, busy, result_valid, err
  );
endinterface

// File: rtl/calc_engine.sv
// calc_engine: decimal keypad calculator core with iterative div/rem/pow/fac.
module calc_engine #(
  parameter int DIGITS = 4,
  parameter int W = 14,
  parameter int RW = 28
) (
  input logic clk,
  input logic rst,
  calc_if.slave bus
);
  localparam int CW = $clog2(DIGITS+1);
  localparam logic [2:0] S_A = 3'd0, S_B = 3'd1, S_CALC = 3'd2, S_DONE = 3'd3, S_ERR = 3'd4;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3, REM = 3'd4, POW = 3'd5, FAC = 3'd6;
  localparam logic [W-1:0] TEN = W'(10);
  logic [2:0] state, n_state, op, n_op, dop, cop;
  logic [W-1:0] a, n_a, b, n_b, cnt, n_cnt, quo, n_quo, d;
  logic [RW-1:0] result, n_res, acc, n_acc;
  logic [CW-1:0] dcnt, n_dcnt;
  logic neg, n_neg, sw_ev, dip_ev, clr, go;
  logic [11:0] sw_q;
  logic [7:0] dip_q;
  logic [RW+W-1:0] prod;
  logic [W:0] r_sh;
  // A press is a one-hot sample that differs from the previous sample; keypad wins ties
  assign sw_ev = bus.key_tick && $onehot(bus.sw) && bus.sw != sw_q;
  assign dip_ev = bus.key_tick && $onehot(bus.dipsw) && bus.dipsw != dip_q && !sw_ev;
  always_comb begin
    d = '0;
    dop = ADD;
    for (int i = 2; i < 12; i++) if (bus.sw[i]) d = W'(11 - i);
    for (int i = 1; i < 8; i++) if (bus.dipsw[i]) dop = 3'(7 - i);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_A;
      op <= ADD;
      a <= '0;
      b <= '0;
      cnt <= '0;
      quo <= '0;
      result <= '0;
      acc <= '0;
      dcnt <= '0;
      neg <= 1'b0;
      sw_q <= '0;
      dip_q <= '0;
    end else begin
      if (bus.key_tick) begin
        sw_q <= bus.sw;
        dip_q <= bus.dipsw;
      end
      state <= n_state;
      op <= n_op;
      a <= n_a;
      b <= n_b;
      cnt <= n_cnt;
      quo <= n_quo;
      result <= n_res;
      acc <= n_acc;
      dcnt <= n_dcnt;
      neg <= n_neg;
    end
  always_comb begin
    n_state = state;
    n_op = op;
    n_a = a;
    n_b = b;
    n_cnt = cnt;
    n_quo = quo;
    n_res = result;
    n_acc = acc;
    n_dcnt = dcnt;
    n_neg = neg;
    clr = 1'b0;
    go = 1'b0;
    cop = op;
    prod = (RW+W)'(acc) * (RW+W)'(op == FAC ? cnt : a);
    r_sh = {acc[W-1:0], quo[W-1]};
    if (sw_ev && bus.sw[0]) clr = 1'b1;
    else if (state == S_CALC) begin
      if ((op == DIV || op == REM) && b == '0) begin
        n_state = S_ERR;
        n_res = '0;
        n_neg = 1'b0;
      end else if (cnt != '0) begin
        n_cnt = cnt - 1'b1;
        if (op == DIV || op == REM) begin
          n_acc = RW'(r_sh >= {1'b0, b} ? r_sh - {1'b0, b} : r_sh);
          n_quo = {quo[W-2:0], r_sh >= {1'b0, b}};
        end else if (|prod[RW+W-1:RW]) begin
          n_state = S_ERR;
          n_res = '0;
          n_neg = 1'b0;
        end else n_acc = prod[RW-1:0];
      end else begin
        n_state = S_DONE;
        n_res = op == ADD ? RW'(a) + RW'(b) :
                op == SUB ? (a >= b ? RW'(a - b) : RW'(b - a)) :
                op == MUL ? RW'(a) * RW'(b) :
                op == DIV ? RW'(quo) : acc;
        n_neg = op == SUB && a < b;
      end
    end else if (sw_ev && |bus.sw[11:2]) begin
      if ((state == S_A || state == S_B) && dcnt < CW'(DIGITS)) begin
        if (state == S_A) n_a = a * TEN + d;
        else n_b = b * TEN + d;
        n_dcnt = dcnt + CW'(1);
      end else if (state == S_DONE) begin
        n_state = S_A;
        n_a = d;
        n_b = '0;
        n_res = '0;
        n_neg = 1'b0;
        n_dcnt = CW'(1);
      end
    end else if (sw_ev) begin
      if (state == S_A) begin
        n_a = '0;
        n_dcnt = '0;
      end else if (state == S_B) begin
        n_b = '0;
        n_dcnt = '0;
      end else if (state == S_DONE) clr = 1'b1;
    end else if (dip_ev) begin
      if (bus.dipsw[0]) begin
        if (state == S_B && dcnt != '0) go = 1'b1;
      end else if (bus.dipsw[1]) begin
        if (state == S_A && dcnt != '0) begin
          go = 1'b1;
          cop = FAC;
        end
      end else if (state == S_A && dcnt != '0) begin
        n_op = dop;
        n_state = S_B;
        n_dcnt = '0;
      end else if (state == S_B) n_op = dop;
      else if (state == S_DONE) begin
        if (!neg && result[RW-1:W] == '0) begin
          n_a = result[W-1:0];
          n_b = '0;
          n_dcnt = '0;
          n_op = dop;
          n_state = S_B;
        end else begin
          n_state = S_ERR;
          n_res = '0;
          n_neg = 1'b0;
        end
      end
    end
    // Iteration counters are primed on entry so div takes exactly W steps plus one finish cycle
    if (go) begin
      n_state = S_CALC;
      n_op = cop;
      n_quo = a;
      n_acc = (cop == DIV || cop == REM) ? '0 : RW'(1);
      n_cnt = (cop == DIV || cop == REM) ? W'(W) : cop == POW ? b : cop == FAC ? a : '0;
    end
    if (clr) begin
      n_state = S_A;
      n_op = ADD;
      n_a = '0;
      n_b = '0;
      n_cnt = '0;
      n_quo = '0;
      n_res = '0;
      n_acc = '0;
      n_dcnt = '0;
      n_neg = 1'b0;
    end
  end
  always_comb begin
    bus.operand_a = a;
    bus.operand_b = b;
    bus.result = result;
    bus.neg = neg;
    bus.op_code = op;
    bus.digit_cnt = dcnt;
    bus.state = state;
    bus.busy = state == S_CALC;
    bus.result_valid = state == S_DONE;
    bus.err = state == S_ERR;
  end
endmodule

// File: doc/calc_engine.md
Name: calc_engine

Overview:
- Parametrised arithmetic core for the keypad/DIP-switch calculator.
- Accepts multi-digit decimal operands from the one-hot digit keypad and an operator from the one-hot DIP switches.
- Computes sum, difference, product, quotient, remainder, power or factorial, using sequential iteration for the multi-cycle operations.
- Presents binary operands and results, plus status flags, to the LCD/7-segment display layer.

Parameters:
- DIGITS, 4, maximum decimal digits per operand.
- W, 14, operand width in bits; must satisfy 10^DIGITS-1 < 2^W.
- RW, 28, result width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key_tick  in  1  one-cycle sample strobe (100 Hz domain pulse); sw/dipsw are sampled only when it is high.
- sw  in  12  keypad, one-hot: sw[11]=0, sw[10]=1, ..., sw[2]=9, sw[1]=clear entry, sw[0]=all clear.
- dipsw  in  8  operator, one-hot: [7]+, [6]-, [5]×, [4]÷, [3]rem, [2]pow, [1]fac, [0]=.
- operand_a  out  W  first operand.
- operand_b  out  W  second operand.
- result  out  RW  magnitude of the result.
- neg  out  1  result is negative (subtraction only).
- op_code  out  3  latched operator: 0 add, 1 sub, 2 mul, 3 div, 4 rem, 5 pow, 6 fac.
- digit_cnt  out  $clog2(DIGITS+1)  digits entered in the current operand.
- state  out  3  FSM state code.
- busy  out  1  high while in S_CALC.
- result_valid  out  1  high while in S_DONE.
- err  out  1  high while in S_ERR.

Behaviour:
- Reset (rst=0): all outputs 0, state=S_A.
- Key events:
  - On key_tick, each of sw and dipsw is registered.
  - An event fires only when the new sample is exactly one-hot and differs from the previous sample (press edge).
  - Multi-hot and all-zero samples produce no event but still update the stored sample.
  - An sw event and a dipsw event on the same tick: the sw event is processed; the dipsw event is dropped.
- States: S_A=0 (enter A), S_B=1 (enter B), S_CALC=2, S_DONE=3, S_ERR=4.
- Digit d in S_A/S_B:
  - If digit_cnt<DIGITS: operand = operand*10+d, digit_cnt+1.
  - Otherwise the digit is ignored.
  - Leading zeros count as digits.
- Digit d in S_DONE: clear A, B, result and neg; A=d, digit_cnt=1, go to S_A.
- Clear entry (sw[1]): in S_A/S_B, zero the current operand and digit_cnt; in S_DONE, behaves as all clear.
- All clear (sw[0]): in any state, including mid-S_CALC, abort and return to the reset values (except the stored samples).
- Operator events:
  - Binary operator (+ - × ÷ rem pow) in S_A with digit_cnt≥1: latch op_code, go to S_B, digit_cnt=0.
  - Binary operator in S_B: replace op_code only.
  - fac in S_A with digit_cnt≥1: go directly to S_CALC.
  - '=' in S_B with digit_cnt≥1: go to S_CALC.
  - Any operator in S_A with digit_cnt=0, or '=' elsewhere: ignored.
- Chaining: a binary operator in S_DONE with neg=0 and result<2^W loads A=result, B=0, digit_cnt=0, latches op_code, goes to S_B. If neg=1 or result≥2^W: go to S_ERR.
- S_CALC, sw digits/clear-entry and dipsw ignored. Latency counts from the cycle S_CALC is entered to the first S_DONE cycle:
  - add: 1 cycle, result=A+B.
  - sub: 1 cycle; A≥B gives result=A−B, neg=0; else result=B−A, neg=1.
  - mul: 1 cycle, result=A*B.
  - div/rem: restoring shift-subtract, exactly W cycles + 1; div gives result=quotient, rem gives result=remainder.
  - pow: accumulator starts at 1; B multiply steps, one per cycle, + 1. B=0 gives 1.
  - fac: accumulator starts at 1; A multiply steps (multiplier counts down from A), + 1. A=0 gives 1.
  - Overflow in a pow/fac step (product ≥2^RW, checked on a full RW+W-bit product): go to S_ERR.
- Divide by zero: B=0 with div/rem goes to S_ERR after 1 cycle.
- S_ERR: result=0, neg=0; only all clear exits.
- Width: all arithmetic is unsigned; operands are zero-extended to RW.

Test Plan:
- Entry: 1,2,3 then + then 4,5 then = → A=123, B=45, result=168 on the second cycle after the '=' event, result_valid=1.
- Subtract/neg: 7 − 9 = → result=2, neg=1; then a + operator → state=S_ERR, err=1; then all clear → state=0, all outputs 0.
- Divide: 1000 ÷ 7 = → busy=1 for exactly W+1=15 cycles, result=142; repeat with rem → result=6; 5 ÷ 0 = → err=1.
- Pow/fac: 2 pow 10 = → 1024 after 11 cycles; 8 fac → 40320; 9999 pow 9 → err=1 (overflow); 0 fac → 1.
- Input rules: five digits 1,2,3,4,5 → A=1234, digit_cnt=4; sw=0x300 (multi-hot) → no change; a key held across 3 ticks → exactly one digit accepted.
- Abort: all clear during a div in S_CALC → next cycle state=S_A, busy=0. Reset asserted mid-S_CALC → outputs 0 immediately (asynchronous), without waiting for a clock edge.
